// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order imem requests, tracks them in a small queue
// and hands filled words to decode; redirects flush and drop stale responses.
module instruction_fetch #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_next,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]    pc_q    [DEPTH];
   logic [31:0]    instr_q [DEPTH];
   logic [DEPTH-1:0] filled_q;

   logic [CW-1:0] alloc_ptr;
   logic [CW-1:0] fill_ptr;
   logic [CW-1:0] head_ptr;
   logic [CW-1:0] stale;
   logic [CW-1:0] used;
   logic [CW-1:0] pend;
   logic [CW:0]   credit;

   logic [PW-1:0] alloc_idx;
   logic [PW-1:0] fill_idx;
   logic [PW-1:0] head_idx;

   logic req_hs;
   logic pop;
   logic fill;
   logic drop;

   assign alloc_idx = alloc_ptr[PW-1:0];
   assign fill_idx  = fill_ptr[PW-1:0];
   assign head_idx  = head_ptr[PW-1:0];

   assign used   = alloc_ptr - head_ptr;
   assign pend   = alloc_ptr - fill_ptr;
   assign credit = {1'b0, used} + {1'b0, stale};

   // Credits cover both live entries and responses owed to flushed streams
   assign imem_req_valid = !rst && !redirect_valid
                         && (credit < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc_cur;
   assign req_hs         = imem_req_valid && imem_req_ready;

   assign if_valid = !rst && !redirect_valid
                   && (used != '0) && filled_q[head_idx];
   assign if_instr = instr_q[head_idx];
   assign if_pc    = pc_q[head_idx];
   assign pop      = if_valid && if_ready;

   assign fill = imem_rsp_valid && !redirect_valid && (stale == '0);
   assign drop = imem_rsp_valid && !redirect_valid && (stale != '0);

   always_comb begin
      pc_next = pc_cur;
      if (rst)
         pc_next = pc_cur;
      else if (redirect_valid)
         pc_next = redirect_pc & 32'hFFFF_FFFC;
      else if (req_hs)
         pc_next = pc_cur + 32'd4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         stale     <= '0;
         filled_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (redirect_valid) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         stale     <= stale + pend - CW'(imem_rsp_valid);
      end else begin
         if (req_hs) begin
            pc_q[alloc_idx]     <= pc_cur;
            filled_q[alloc_idx] <= 1'b0;
            alloc_ptr           <= alloc_ptr + 1'b1;
         end
         if (fill) begin
            instr_q[fill_idx]  <= imem_rsp_data;
            filled_q[fill_idx] <= 1'b1;
            fill_ptr           <= fill_ptr + 1'b1;
         end else if (drop) begin
            stale <= stale - 1'b1;
         end
         if (pop)
            head_ptr <= head_ptr + 1'b1;
      end
   end

endmodule
